// File: rtl/alu_issue_stage.sv
// ID/EX issue stage: 2-entry skid buffer feeding the ALU with EX/MEM and MEM/WB operand forwarding.
// Optional ALU_ISSUE_STATS_EN adds STALL_CNT / FLUSH_CNT performance counters.
module alu_issue_stage #(
    parameter int XLEN = 32,
    parameter int REGW = 5
) (
    input  logic            CLK,
    input  logic            RESET,
    input  logic            FLUSH,
    input  logic            ID_VALID,
    output logic            ID_READY,
    input  logic [3:0]      ID_SELECT,
    input  logic [REGW-1:0] ID_RS1,
    input  logic [REGW-1:0] ID_RS2,
    input  logic [REGW-1:0] ID_RD,
    input  logic [XLEN-1:0] ID_RS1_VAL,
    input  logic [XLEN-1:0] ID_RS2_VAL,
    input  logic [XLEN-1:0] ID_IMM,
    input  logic            ID_USE_IMM,
    input  logic            EXMEM_WE,
    input  logic            MEMWB_WE,
    input  logic [REGW-1:0] EXMEM_RD,
    input  logic [REGW-1:0] MEMWB_RD,
    input  logic [XLEN-1:0] EXMEM_VAL,
    input  logic [XLEN-1:0] MEMWB_VAL,
    output logic            EX_VALID,
    input  logic            EX_READY,
    output logic [XLEN-1:0] DATA1,
    output logic [XLEN-1:0] DATA2,
    output logic [3:0]      SELECT,
    output logic [REGW-1:0] EX_RD
`ifdef ALU_ISSUE_STATS_EN
    ,
    output logic [31:0]     STALL_CNT,
    output logic [15:0]     FLUSH_CNT
`endif
);

    typedef struct packed {
        logic            valid;
        logic [3:0]      sel;
        logic [REGW-1:0] rs1;
        logic [REGW-1:0] rs2;
        logic [REGW-1:0] rd;
        logic [XLEN-1:0] rs1_val;
        logic [XLEN-1:0] rs2_val;
        logic [XLEN-1:0] imm;
        logic            use_imm;
    } entry_t;

    entry_t head_q, skid_q;
    entry_t head_d, skid_d;
    entry_t incoming, incoming_s, head_s, skid_s;

    logic            accept;
    logic            consume;
    logic [XLEN-1:0] src1, src2, data2_live;
    logic [XLEN-1:0] last_data1, last_data2;
    logic [3:0]      last_sel;
    logic [REGW-1:0] last_rd;

    // Capture a MEM/WB write into the stored source values so it survives the writer retiring.
    function automatic entry_t snoop(input entry_t e, input logic we,
                                     input logic [REGW-1:0] wrd, input logic [XLEN-1:0] wval);
        entry_t r;
        r = e;
        if (we && (wrd == e.rs1) && (e.rs1 != '0)) r.rs1_val = wval;
        if (we && (wrd == e.rs2) && (e.rs2 != '0)) r.rs2_val = wval;
        return r;
    endfunction

    function automatic logic [XLEN-1:0] fwd(input logic [REGW-1:0] rs, input logic [XLEN-1:0] stored,
                                            input logic ex_we, input logic [REGW-1:0] ex_rd,
                                            input logic [XLEN-1:0] ex_val,
                                            input logic wb_we, input logic [REGW-1:0] wb_rd,
                                            input logic [XLEN-1:0] wb_val);
        logic [XLEN-1:0] r;
        r = stored;
        if (rs != '0) begin
            if (ex_we && (ex_rd == rs))      r = ex_val;
            else if (wb_we && (wb_rd == rs)) r = wb_val;
        end
        return r;
    endfunction

    assign ID_READY = !skid_q.valid;
    assign accept   = ID_VALID && !skid_q.valid;
    assign consume  = head_q.valid && EX_READY;

    always_comb begin
        incoming         = '0;
        incoming.valid   = 1'b1;
        incoming.sel     = ID_SELECT;
        incoming.rs1     = ID_RS1;
        incoming.rs2     = ID_RS2;
        incoming.rd      = ID_RD;
        incoming.rs1_val = ID_RS1_VAL;
        incoming.rs2_val = ID_RS2_VAL;
        incoming.imm     = ID_IMM;
        incoming.use_imm = ID_USE_IMM;

        incoming_s = snoop(incoming, MEMWB_WE, MEMWB_RD, MEMWB_VAL);
        head_s     = snoop(head_q, MEMWB_WE, MEMWB_RD, MEMWB_VAL);
        skid_s     = snoop(skid_q, MEMWB_WE, MEMWB_RD, MEMWB_VAL);

        head_d = head_s;
        skid_d = skid_s;

        if (FLUSH) begin
            head_d.valid = 1'b0;
            skid_d.valid = 1'b0;
        end else if (consume) begin
            if (skid_q.valid) begin
                head_d = skid_s;
                if (accept) skid_d = incoming_s;
                else        skid_d.valid = 1'b0;
            end else if (accept) begin
                head_d = incoming_s;
            end else begin
                head_d.valid = 1'b0;
            end
        end else if (accept) begin
            if (!head_q.valid) head_d = incoming_s;
            else               skid_d = incoming_s;
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            head_q <= '0;
            skid_q <= '0;
        end else begin
            head_q <= head_d;
            skid_q <= skid_d;
        end
    end

    always_comb begin
        src1 = fwd(head_q.rs1, head_q.rs1_val, EXMEM_WE, EXMEM_RD, EXMEM_VAL,
                   MEMWB_WE, MEMWB_RD, MEMWB_VAL);
        src2 = fwd(head_q.rs2, head_q.rs2_val, EXMEM_WE, EXMEM_RD, EXMEM_VAL,
                   MEMWB_WE, MEMWB_RD, MEMWB_VAL);
        data2_live = head_q.use_imm ? head_q.imm : src2;
    end

    // Last presented values, replayed while the head is empty so the ALU inputs stay quiet.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            last_data1 <= '0;
            last_data2 <= '0;
            last_sel   <= '0;
            last_rd    <= '0;
        end else if (head_q.valid) begin
            last_data1 <= src1;
            last_data2 <= data2_live;
            last_sel   <= head_q.sel;
            last_rd    <= head_q.rd;
        end
    end

    assign EX_VALID = head_q.valid;
    assign DATA1    = head_q.valid ? src1       : last_data1;
    assign DATA2    = head_q.valid ? data2_live : last_data2;
    assign SELECT   = head_q.valid ? head_q.sel : last_sel;
    assign EX_RD    = head_q.valid ? head_q.rd  : last_rd;

`ifdef ALU_ISSUE_STATS_EN
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            STALL_CNT <= '0;
            FLUSH_CNT <= '0;
        end else begin
            if (head_q.valid && !EX_READY)                  STALL_CNT <= STALL_CNT + 32'd1;
            if (FLUSH && (head_q.valid || skid_q.valid))    FLUSH_CNT <= FLUSH_CNT + 16'd1;
        end
    end
`else
`endif

endmodule

// File: tb/tb_alu_issue_stage.sv
// Scoreboard bench for alu_issue_stage: directed ops with hand-computed ALU operands.
module tb_alu_issue_stage;
    logic        CLK = 1'b0;
    logic        RESET = 1'b0;
    logic        FLUSH = 1'b0;
    logic        ID_VALID = 1'b0;
    logic        ID_READY;
    logic [3:0]  ID_SELECT = '0;
    logic [4:0]  ID_RS1 = '0, ID_RS2 = '0, ID_RD = '0;
    logic [31:0] ID_RS1_VAL = '0, ID_RS2_VAL = '0, ID_IMM = '0;
    logic        ID_USE_IMM = 1'b0;
    logic        EXMEM_WE = 1'b0, MEMWB_WE = 1'b0;
    logic [4:0]  EXMEM_RD = '0, MEMWB_RD = '0;
    logic [31:0] EXMEM_VAL = '0, MEMWB_VAL = '0;
    logic        EX_VALID;
    logic        EX_READY = 1'b0;
    logic [31:0] DATA1, DATA2;
    logic [3:0]  SELECT;
    logic [4:0]  EX_RD;

    alu_issue_stage #(.XLEN(32), .REGW(5)) dut (
        .CLK(CLK), .RESET(RESET), .FLUSH(FLUSH),
        .ID_VALID(ID_VALID), .ID_READY(ID_READY), .ID_SELECT(ID_SELECT),
        .ID_RS1(ID_RS1), .ID_RS2(ID_RS2), .ID_RD(ID_RD),
        .ID_RS1_VAL(ID_RS1_VAL), .ID_RS2_VAL(ID_RS2_VAL), .ID_IMM(ID_IMM), .ID_USE_IMM(ID_USE_IMM),
        .EXMEM_WE(EXMEM_WE), .MEMWB_WE(MEMWB_WE), .EXMEM_RD(EXMEM_RD), .MEMWB_RD(MEMWB_RD),
        .EXMEM_VAL(EXMEM_VAL), .MEMWB_VAL(MEMWB_VAL),
        .EX_VALID(EX_VALID), .EX_READY(EX_READY),
        .DATA1(DATA1), .DATA2(DATA2), .SELECT(SELECT), .EX_RD(EX_RD)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [3:0]  sel;
        logic [4:0]  rs1, rs2, rd;
        logic [31:0] v1, v2, imm;
        logic        ui;
        logic [31:0] e1, e2;
    } vec_t;

    vec_t sb[$];
    vec_t mon_e;
    int   pop_cyc[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;

    always @(posedge CLK) cyc = cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests = tests + 1;
        if (act !== exp) begin
            fails = fails + 1;
            $display("FAIL %s: got 0x%08h, want 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic [3:0] sel, input logic [4:0] rs1, input logic [4:0] rs2,
                                input logic [4:0] rd, input logic [31:0] v1, input logic [31:0] v2,
                                input logic [31:0] imm, input logic ui,
                                input logic [31:0] e1, input logic [31:0] e2);
        vec_t v;
        v.sel = sel; v.rs1 = rs1; v.rs2 = rs2; v.rd = rd;
        v.v1 = v1; v.v2 = v2; v.imm = imm; v.ui = ui; v.e1 = e1; v.e2 = e2;
        return v;
    endfunction

    // Monitor: every op consumed by EX is checked against the oldest expected entry.
    always @(negedge CLK) begin
        if (RESET && !FLUSH && EX_VALID && EX_READY) begin
            if (sb.size() == 0) begin
                tests = tests + 1;
                fails = fails + 1;
                $display("FAIL unexpected_issue: got sel=%0h data1=0x%08h, want no op", SELECT, DATA1);
            end else begin
                mon_e = sb.pop_front();
                chk("select", {28'd0, SELECT}, {28'd0, mon_e.sel});
                chk("data1", DATA1, mon_e.e1);
                chk("data2", DATA2, mon_e.e2);
                chk("ex_rd", {27'd0, EX_RD}, {27'd0, mon_e.rd});
                pop_cyc.push_back(cyc);
            end
        end
        if (RESET && FLUSH) sb.delete();
    end

    // Offer one op; push its expectation when the accept edge passes. Call at posedge+1.
    task automatic offer(input vec_t v);
        bit r, f;
        bit done;
        done = 1'b0;
        ID_VALID = 1'b1; ID_SELECT = v.sel; ID_RS1 = v.rs1; ID_RS2 = v.rs2; ID_RD = v.rd;
        ID_RS1_VAL = v.v1; ID_RS2_VAL = v.v2; ID_IMM = v.imm; ID_USE_IMM = v.ui;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge CLK);
            r = ID_READY;
            f = FLUSH;
            @(posedge CLK);
            if (r) begin
                if (!f) sb.push_back(v);
                done = 1'b1;
            end
        end
        #1;
        ID_VALID = 1'b0;
        if (!done) begin
            tests = tests + 1;
            fails = fails + 1;
            $display("FAIL offer_timeout: got no accept in 50 cycles, want accept");
        end
    endtask

    task automatic settle();
        @(posedge CLK);
        #1;
    endtask

    task automatic wait_empty();
        for (int i = 0; i < 60; i++) begin
            @(negedge CLK);
            #1;
            if (sb.size() == 0) break;
        end
        chk("drain_empty", 32'(sb.size()), 32'd0);
        settle();
    endtask

    int base;

    initial begin
        // Reset state
        repeat (2) @(negedge CLK);
        chk("rst_ex_valid", {31'd0, EX_VALID}, 32'd0);
        chk("rst_id_ready", {31'd0, ID_READY}, 32'd1);
        chk("rst_select", {28'd0, SELECT}, 32'd0);
        chk("rst_data1", DATA1, 32'd0);
        chk("rst_data2", DATA2, 32'd0);
        chk("rst_ex_rd", {27'd0, EX_RD}, 32'd0);
        @(posedge CLK); #1;
        RESET = 1'b1;
        settle();

        // Single op, one-cycle latency, then bubble with held outputs
        EX_READY = 1'b1;
        offer(mk(4'b0010, 5'd1, 5'd2, 5'd5, 32'd5, 32'd7, 32'd0, 1'b0, 32'd5, 32'd7));
        @(negedge CLK);
        chk("t1_ex_valid", {31'd0, EX_VALID}, 32'd1);
        settle();
        @(negedge CLK);
        chk("t1_bubble", {31'd0, EX_VALID}, 32'd0);
        chk("t1_hold_data1", DATA1, 32'd5);
        chk("t1_hold_data2", DATA2, 32'd7);
        chk("t1_hold_select", {28'd0, SELECT}, 32'd2);
        settle();

        // Backpressure: A, B fill the buffer, C waits, then all drain back to back
        EX_READY = 1'b0;
        base = pop_cyc.size();
        offer(mk(4'b0000, 5'd6, 5'd7, 5'd8, 32'h11, 32'h22, 32'd0, 1'b0, 32'h11, 32'h22));
        offer(mk(4'b0011, 5'd9, 5'd10, 5'd11, 32'h33, 32'h44, 32'd0, 1'b0, 32'h33, 32'h44));
        fork
            offer(mk(4'b0110, 5'd12, 5'd13, 5'd14, 32'h55, 32'h66, 32'd0, 1'b0, 32'h55, 32'h66));
            begin
                @(negedge CLK);
                chk("t2_id_ready_full", {31'd0, ID_READY}, 32'd0);
                chk("t2_ex_valid", {31'd0, EX_VALID}, 32'd1);
                repeat (2) @(posedge CLK);
                #1;
                EX_READY = 1'b1;
            end
        join
        wait_empty();
        chk("t2_pop_count", 32'(pop_cyc.size() - base), 32'd3);
        if (pop_cyc.size() - base == 3) begin
            chk("t2_gap_ab", 32'(pop_cyc[base+1] - pop_cyc[base]), 32'd1);
            chk("t2_gap_bc", 32'(pop_cyc[base+2] - pop_cyc[base+1]), 32'd1);
        end

        // Forwarding priority and x0
        EXMEM_WE = 1'b1; EXMEM_RD = 5'd3; EXMEM_VAL = 32'hAA;
        MEMWB_WE = 1'b1; MEMWB_RD = 5'd3; MEMWB_VAL = 32'hBB;
        offer(mk(4'b0010, 5'd3, 5'd12, 5'd13, 32'h1, 32'h2, 32'd0, 1'b0, 32'hAA, 32'h2));
        offer(mk(4'b0001, 5'd12, 5'd3, 5'd13, 32'h21, 32'h22, 32'd0, 1'b0, 32'h21, 32'hAA));
        settle();
        EXMEM_RD = 5'd0; MEMWB_RD = 5'd0;
        offer(mk(4'b0010, 5'd0, 5'd0, 5'd1, 32'h77, 32'h88, 32'd0, 1'b0, 32'h77, 32'h88));
        settle();
        EXMEM_WE = 1'b0; EXMEM_RD = 5'd3; MEMWB_RD = 5'd3;
        offer(mk(4'b0011, 5'd3, 5'd3, 5'd2, 32'h5, 32'h6, 32'd0, 1'b0, 32'hBB, 32'hBB));
        settle();
        MEMWB_WE = 1'b0;
        wait_empty();

        // Stalled head captures a one-cycle MEM/WB write to rs2
        EX_READY = 1'b0;
        offer(mk(4'b0001, 5'd1, 5'd4, 5'd2, 32'h10, 32'h0, 32'd0, 1'b0, 32'h10, 32'h1234));
        MEMWB_WE = 1'b1; MEMWB_RD = 5'd4; MEMWB_VAL = 32'h1234;
        settle();
        MEMWB_WE = 1'b0; MEMWB_VAL = 32'hDEADBEEF;
        repeat (3) @(posedge CLK);
        #1;
        EX_READY = 1'b1;
        wait_empty();

        // Immediate operand wins over an rs2 forward match
        EXMEM_WE = 1'b1; EXMEM_RD = 5'd4; EXMEM_VAL = 32'hDEAD;
        MEMWB_WE = 1'b1; MEMWB_RD = 5'd4; MEMWB_VAL = 32'hBEEF;
        offer(mk(4'b1010, 5'd0, 5'd4, 5'd7, 32'h9, 32'h5, 32'hFFFFFFF0, 1'b1, 32'h9, 32'hFFFFFFF0));
        settle();
        EXMEM_WE = 1'b0; MEMWB_WE = 1'b0;
        wait_empty();

        // Flush with both entries full, offered op and consume both overridden
        EX_READY = 1'b0;
        offer(mk(4'b0100, 5'd1, 5'd2, 5'd3, 32'h1, 32'h3, 32'd0, 1'b0, 32'h1, 32'h3));
        offer(mk(4'b0101, 5'd5, 5'd6, 5'd7, 32'h40, 32'h2, 32'd0, 1'b0, 32'h40, 32'h2));
        @(negedge CLK);
        chk("t6_full_ready", {31'd0, ID_READY}, 32'd0);
        settle();
        FLUSH = 1'b1; EX_READY = 1'b1;
        ID_VALID = 1'b1; ID_SELECT = 4'b0111; ID_RS1 = 5'd8; ID_RS1_VAL = 32'h99;
        settle();
        FLUSH = 1'b0; ID_VALID = 1'b0;
        @(negedge CLK);
        chk("t6_flush_ex_valid", {31'd0, EX_VALID}, 32'd0);
        chk("t6_flush_id_ready", {31'd0, ID_READY}, 32'd1);
        chk("t6_hold_data1", DATA1, 32'h1);
        chk("t6_hold_select", {28'd0, SELECT}, 32'd4);
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            chk("t6_no_emit", {31'd0, EX_VALID}, 32'd0);
        end
        settle();

        // Flush with a single entry: the op offered (and acceptable) in the flush cycle is dropped
        EX_READY = 1'b0;
        offer(mk(4'b0000, 5'd1, 5'd2, 5'd3, 32'hF0, 32'h0F, 32'd0, 1'b0, 32'hF0, 32'h0F));
        FLUSH = 1'b1;
        ID_VALID = 1'b1; ID_SELECT = 4'b0010; ID_RS1 = 5'd0; ID_RS1_VAL = 32'h1;
        settle();
        FLUSH = 1'b0; ID_VALID = 1'b0;
        @(negedge CLK);
        chk("t6b_drop_ex_valid", {31'd0, EX_VALID}, 32'd0);
        settle();
        EX_READY = 1'b1;
        repeat (2) settle();

        // Reset mid-stream
        EX_READY = 1'b0;
        offer(mk(4'b0010, 5'd1, 5'd2, 5'd3, 32'h31, 32'h32, 32'd0, 1'b0, 32'h31, 32'h32));
        offer(mk(4'b0010, 5'd1, 5'd2, 5'd3, 32'h41, 32'h42, 32'd0, 1'b0, 32'h41, 32'h42));
        #2;
        RESET = 1'b0;
        #1;
        chk("t7_rst_ex_valid", {31'd0, EX_VALID}, 32'd0);
        chk("t7_rst_id_ready", {31'd0, ID_READY}, 32'd1);
        chk("t7_rst_data1", DATA1, 32'd0);
        sb.delete();
        @(posedge CLK); #1;
        RESET = 1'b1;
        settle();
        EX_READY = 1'b1;
        offer(mk(4'b0110, 5'd2, 5'd3, 5'd9, 32'h100, 32'h1, 32'd0, 1'b0, 32'h100, 32'h1));
        wait_empty();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
- ID/EX pipeline stage that drives the ALU operand and opcode inputs (DATA1, DATA2, SELECT).
- Accepts decoded ALU operations from decode over a valid/ready handshake and buffers them in a 2-entry skid buffer.
- Applies operand forwarding from EX/MEM and MEM/WB, then presents operands and opcode to the ALU with a valid/ready handshake toward EX.

Parameters:
XLEN, 32, operand/result width
REGW, 5, register index width

Ports:
CLK  in  1  clock, rising edge
RESET  in  1  asynchronous active-low reset
FLUSH  in  1  synchronous kill of all buffered ops (branch mispredict)
ID_VALID  in  1  decode presents an op
ID_READY  out  1  stage can accept an op
ID_SELECT  in  4  ALU opcode (0000 AND, 0001 OR, 0010 ADD, 0011 XOR, 0100 SLL, 0101 SRL, 0110 SUB, 0111 SRA, 1010 pass DATA2)
ID_RS1, ID_RS2  in  REGW  source register indices
ID_RD  in  REGW  destination index
ID_RS1_VAL, ID_RS2_VAL  in  XLEN  register-file read values
ID_IMM  in  XLEN  sign-extended immediate
ID_USE_IMM  in  1  DATA2 comes from ID_IMM instead of rs2
EXMEM_WE, MEMWB_WE  in  1  older-stage write enables
EXMEM_RD, MEMWB_RD  in  REGW  older-stage destinations
EXMEM_VAL, MEMWB_VAL  in  XLEN  older-stage results
EX_VALID  out  1  op presented to ALU
EX_READY  in  1  EX consumes op this cycle
DATA1, DATA2  out  XLEN  ALU operands after forwarding
SELECT  out  4  ALU opcode
EX_RD  out  REGW  destination carried to EX

Behaviour:
- Reset (RESET=0, async): both entries invalid; EX_VALID=0; ID_READY=1; SELECT=0000; DATA1, DATA2, EX_RD = 0. Reset mid-transfer discards all entries, with no partial state retained.
- Storage: head entry (drives outputs) plus skid entry. Each entry holds SELECT, RS1, RS2, RD, RS1_VAL, RS2_VAL, IMM, USE_IMM, and valid.
- Accept: an op is accepted when ID_VALID && ID_READY at the clock edge. ID_READY is registered and equals !skid_valid.
- Latency: an accepted op appears with EX_VALID=1 on the next cycle.
- Fill and drain:
  - Empty: an accepted op fills the head.
  - Head holds an op and EX does not consume it: an accepted op fills the skid.
  - EX consumes the head: the skid moves to the head.
  - EX consumes the head and a new op is accepted in the same cycle: the new op goes to the head if the skid is empty, otherwise the skid moves to the head and the new op goes to the skid.
- Full: both entries valid, so ID_READY=0 on the following cycle. Back-to-back throughput is 1 op/cycle while EX_READY=1.
- EX_VALID=0: outputs hold their last values, with no X propagation.
- Forwarding (combinational on the head entry, re-evaluated every cycle while stalled):
  - Default src1 = RS1_VAL.
  - If EXMEM_WE && EXMEM_RD==RS1 && RS1!=0, src1 = EXMEM_VAL.
  - Otherwise, if MEMWB_WE && MEMWB_RD==RS1 && RS1!=0, src1 = MEMWB_VAL.
  - EX/MEM has priority over MEM/WB. Register x0 is never forwarded.
  - The same rules apply to src2.
- Operand mux: DATA1 = src1. DATA2 = IMM if USE_IMM, else src2. Widths are exact XLEN with no extension in this stage.
- While a head op stalls, any MEM/WB write to its RS1/RS2 is captured into the stored RS*_VAL. The value therefore survives after the writer leaves the pipeline. The skid entry snoops in the same way.
- FLUSH:
  - Invalidates both entries at the edge. EX_VALID=0 and ID_READY=1 next cycle.
  - An ID op offered in the flush cycle is dropped.
  - FLUSH overrides a simultaneous accept and consume.
- Opcode codes other than those listed are passed through unchanged; the ALU defaults them.

Optional Feature:
ALU_ISSUE_STATS_EN
- When defined, adds output STALL_CNT (32 bits) and output FLUSH_CNT (16 bits).
- STALL_CNT increments each cycle EX_VALID && !EX_READY.
- FLUSH_CNT increments each cycle FLUSH kills at least one valid entry.
- Both counters reset to 0 and wrap at their maximum.
- When not defined, no counters or ports exist and behaviour is otherwise identical.

Test Plan:
- Reset then one op (ID_SELECT=0010, RS1_VAL=5, RS2_VAL=7, USE_IMM=0, EX_READY=1) -> next cycle EX_VALID=1, SELECT=0010, DATA1=5, DATA2=7; the cycle after that, EX_VALID=0.
- EX_READY=0 while offering 3 ops A, B, C on consecutive cycles -> A and B accepted, ID_READY=0 and C held; raise EX_READY -> A, B, C exit in order on 3 consecutive cycles.
- Head RS1=3; EXMEM_WE=1, EXMEM_RD=3, EXMEM_VAL=0xAA; MEMWB_WE=1, MEMWB_RD=3, MEMWB_VAL=0xBB -> DATA1=0xAA. Repeat with RS1=0 and both RD=0 -> DATA1=RS1_VAL.
- Stalled head with RS2=4; MEMWB writes 0x1234 to x4 for one cycle, then EX_READY=1 three cycles later with USE_IMM=0 -> DATA2=0x1234.
- USE_IMM=1, ID_IMM=0xFFFFFFF0, SELECT=1010 -> DATA2=0xFFFFFFF0 regardless of the rs2 forward match.
- Both entries full, assert FLUSH with ID_VALID=1 -> next cycle EX_VALID=0, ID_READY=1, no op emitted. Assert RESET low mid-stream -> EX_VALID=0 immediately.
